event_delay_queue: RTL
======================

Name: event_delay_queue

Overview:
- Multi-event programmable delay line for sparse valid/ready streams in the neuron datapath.
- Accepts tagged events (spikes/partial-sum strobes with payload) and re-emits each exactly cfg_delay+1 cycles after acceptance, in arrival order.
- Unlike a fixed shift-register delay, it holds up to DEPTH in-flight events, supports runtime-selectable delay and honours downstream backpressure.
- Sits between a layer's event producer and the consuming accumulator stage.

Parameters:
- DATA_W, 8: event payload width.
- DEPTH, 8: max in-flight events; power of 2, >=2.
- DLY_W, 8: width of cfg_delay; max delay 2^DLY_W-1 cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-high reset (asserted = 1 resets on the clock edge).
- cfg_delay  input  DLY_W  delay applied to an event, sampled at its acceptance.
- in_valid  input  1  upstream event present.
- in_ready  output  1  queue can accept.
- in_data  input  DATA_W  event payload.
- out_valid  output  1  head event ripe.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  head payload.
- occupancy  output  $clog2(DEPTH)+1  stored events.

Behaviour:
- Reset: all entries invalid, pointers/timer = 0; in_ready=1 in the first cycle after reset; out_valid=0; out_data=0; occupancy=0. A reset mid-operation flushes all events; nothing emits afterwards.
- Timer: free-running, DLY_W+1 bits, increments every cycle, wraps.
- Accept (in_valid && in_ready) at timer value T stores {in_data, due = T+cfg_delay+1 mod 2^(DLY_W+1)}, ripe=0.
- Ripe marking:
  - Every cycle, every valid entry with due == timer sets its sticky ripe bit.
  - All entries are compared, not just the head, so a short-delay event behind a long-delay one is never missed.
- Output:
  - out_valid = head valid && head ripe, registered-state driven (no combinational path from in_*).
  - An event accepted at cycle N with delay D is first presented at cycle N+D+1 if it is the head and unblocked.
  - Order is strict FIFO: an event ripening behind an unripe head waits until the head pops.
- Pop (out_valid && out_ready): head invalidated, read pointer advances; the next ripe head may be presented in the following cycle (back-to-back at 1/cycle).
- Handshakes:
  - out_data/out_valid stay stable while out_valid && !out_ready.
  - in_ready = !full; a push is refused when full even if a pop occurs in the same cycle.
  - When not full, a simultaneous push and pop are both honoured, and occupancy is unchanged.
- Empty: out_valid=0; out_data holds its last value.
- cfg_delay changes affect only subsequently accepted events.
- Wrap: due arithmetic is modulo 2^(DLY_W+1). Once set, the ripe bit persists through arbitrarily long stalls, so timer wrap never un-ripes an entry.

Optional Feature:
- Macro: EVENT_DELAY_QUEUE_LATE_STATS_EN.
- With the macro defined:
  - Extra output late_count[15:0], saturating at 16'hFFFF.
  - Increments once per popped event whose pop cycle is later than its due cycle (backpressure or blocking head).
  - Synchronous reset clears it to 0.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package event_delay_pkg:
  - Default constants DEF_DATA_W, DEF_DEPTH, DEF_DLY_W.
  - Function for the occupancy width.
  - Struct typedef for an entry {valid, ripe, due, data} at default widths for bench use.
- One sub-module, edq_ripe_tracker:
  - Holds per-entry due/valid/ripe registers and the parallel due==timer compare.
  - Top level owns pointers, handshakes and the optional stats.

Test Plan:
- Single event, cfg_delay=3, data=8'hA5 accepted at cycle 10 -> out_valid rises exactly at cycle 14 with out_data=A5, out_ready=1, popped at cycle 14.
- cfg_delay=0 -> event accepted at cycle N is presented at N+1; burst of 8 events back-to-back with out_ready=1 -> 8 outputs on consecutive cycles, same order.
- Event A delay=20 then B delay=2 -> B is not emitted before A; A at +21, B the cycle after A (late_count=1 if enabled).
- Fill 8 events with out_ready=0 -> in_ready=0 and occupancy=8; ninth in_valid is not accepted. Then push+pop in the same full cycle -> only the pop is honoured, occupancy=7.
- Hold out_ready=0 for 600 cycles (beyond the 512-cycle timer wrap) on a ripe event -> out_valid and out_data stay stable throughout, then pop succeeds.
- Assert rst_n for 1 cycle with 5 events in flight -> occupancy=0, out_valid=0 next cycle, no emission for the following 300 cycles.

Source files
------------

// File: rtl/event_delay_pkg.sv
// Shared constants and types for the event delay queue.
// Optional late-pop statistics: EVENT_DELAY_QUEUE_LATE_STATS_EN.
package event_delay_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DLY_W  = 8;

    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic                  ripe;
        logic [DEF_DLY_W:0]    due;
        logic [DEF_DATA_W-1:0] data;
    } edq_entry_t;

endpackage

// File: rtl/edq_ripe_tracker.sv
// Per-entry valid/ripe/due state with a parallel due==timer compare.
// Ripe bits are sticky so a timer wrap never un-ripes a stalled entry.
module edq_ripe_tracker
    import event_delay_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DLY_W = DEF_DLY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DLY_W:0]   timer_i,
    input  logic             push_i,
    input  logic [AW-1:0]    push_idx_i,
    input  logic [DLY_W:0]   push_due_i,
    input  logic             pop_i,
    input  logic [AW-1:0]    pop_idx_i,
    output logic [DEPTH-1:0] valid_o,
    output logic [DEPTH-1:0] ripe_q_o,
    output logic [DEPTH-1:0] match_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ripe_q, ripe_d;
    logic [DLY_W:0]   due_q [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_q[i] && (due_q[i] == timer_i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        ripe_d  = ripe_q | match_o;
        if (pop_i) begin
            valid_d[pop_idx_i] = 1'b0;
            ripe_d[pop_idx_i]  = 1'b0;
        end
        // A push only lands in a free slot, so it never collides with the pop.
        if (push_i) begin
            valid_d[push_idx_i] = 1'b1;
            ripe_d[push_idx_i]  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            ripe_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                due_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ripe_q  <= ripe_d;
            if (push_i) begin
                due_q[push_idx_i] <= push_due_i;
            end
        end
    end

    assign valid_o  = valid_q;
    assign ripe_q_o = ripe_q;

endmodule

// File: rtl/event_delay_queue.sv
// Programmable multi-event delay line with in-order release and backpressure.
// Optional late-pop counter: EVENT_DELAY_QUEUE_LATE_STATS_EN.
module event_delay_queue
    import event_delay_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DLY_W  = DEF_DLY_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DLY_W-1:0]          cfg_delay,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
`ifdef EVENT_DELAY_QUEUE_LATE_STATS_EN
    output logic [15:0]               late_count,
`endif
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = occ_w(DEPTH);
    localparam int TW = DLY_W + 1;

    logic [TW-1:0]     timer_q;
    logic [AW-1:0]     rd_q, wr_q;
    logic [OW-1:0]     cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] last_q;

    logic [DEPTH-1:0]  ent_valid, ent_ripe_q, ent_match;
    logic              full, head_ripe, push, pop;
    logic [TW-1:0]     push_due;

    assign full      = (cnt_q == OW'(DEPTH));
    assign in_ready  = !full;
    // The head is presented in its due cycle via the live match, later via the sticky bit.
    assign head_ripe = ent_ripe_q[rd_q] | ent_match[rd_q];
    assign out_valid = ent_valid[rd_q] & head_ripe;
    assign out_data  = out_valid ? mem_q[rd_q] : last_q;
    assign occupancy = cnt_q;

    assign push     = in_valid && !full;
    assign pop      = out_valid && out_ready;
    assign push_due = timer_q + TW'(cfg_delay) + TW'(1);

    edq_ripe_tracker #(
        .DEPTH (DEPTH),
        .DLY_W (DLY_W),
        .AW    (AW)
    ) u_tracker (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .timer_i    (timer_q),
        .push_i     (push),
        .push_idx_i (wr_q),
        .push_due_i (push_due),
        .pop_i      (pop),
        .pop_idx_i  (rd_q),
        .valid_o    (ent_valid),
        .ripe_q_o   (ent_ripe_q),
        .match_o    (ent_match)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            timer_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + OW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - OW'(1);
            end
            if (out_valid) begin
                last_q <= mem_q[rd_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= in_data;
        end
    end

`ifdef EVENT_DELAY_QUEUE_LATE_STATS_EN
    logic [15:0] late_q;

    // A set sticky bit at pop time means the due cycle is already behind us.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            late_q <= '0;
        end else if (pop && ent_ripe_q[rd_q] && (late_q != 16'hFFFF)) begin
            late_q <= late_q + 16'd1;
        end
    end

    assign late_count = late_q;
`endif

endmodule
